// File: rtl/gpu_cmd_host.sv
// rtl/gpu_cmd_host.sv - host byte-stream packet parser driving graphics card operations
module gpu_cmd_host #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1048575
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] X1,
    output logic [7:0] Y1,
    output logic [8:0] X2,
    output logic [7:0] Y2,
    output logic [8:0] op_x_width,
    output logic [7:0] op_y_height,
    output logic       fill_value,
    output logic       start_fill,
    output logic       start_blit,
    output logic       start_ram_read,
    output logic       start_ram_write,
    output logic [7:0] write_ram_byte,
    input  logic       busy,
    input  logic       error,
    input  logic       ram_byte_ready,
    input  logic [7:0] ram_byte,
    output logic       host_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);
    localparam logic [7:0] OP_FILL  = 8'h01;
    localparam logic [7:0] OP_BLIT  = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE, S_ARGS, S_ISSUE, S_WAIT, S_WDATA, S_WWAIT, S_STATUS
    } state_t;

    state_t      state;
    logic [7:0]  opcode;
    logic [3:0]  argc;
    logic [3:0]  last_arg;
    logic [15:0] wr_left;
    logic        first_cyc;
    logic [19:0] wait_cnt;
    logic        to_flag, err_flag, ovf_flag, bad_flag;
    logic        stat_pending;
    logic [7:0]  stat_byte;
    logic [7:0]  stat_code;
    logic [7:0]  wr_byte_q;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic        fifo_empty, fifo_full, pop, push_ok;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop        = !stat_pending && !fifo_empty && out_ready;
    assign push_ok    = ram_byte_ready && (!fifo_full || pop);

    // Once the status byte is presented it owns the output until accepted,
    // so late read-back bytes cannot disturb a byte the sink is looking at.
    assign out_valid = stat_pending || !fifo_empty;
    assign out_byte  = stat_pending ? stat_byte : (fifo_empty ? 8'h00 : mem[rp]);

    assign in_ready  = (state == S_IDLE) || (state == S_ARGS) || (state == S_WDATA);
    assign host_busy = (state != S_IDLE);

    // Data bytes are forwarded to the card in the cycle they are accepted.
    assign start_ram_write = (state == S_WDATA) && in_valid;
    assign write_ram_byte  = start_ram_write ? in_byte : wr_byte_q;

    always_comb begin
        last_arg = 4'd5;
        case (opcode)
            OP_FILL:  last_arg = 4'd6;
            OP_BLIT:  last_arg = 4'd8;
            OP_WRITE: last_arg = 4'd7;
            default:  last_arg = 4'd5;
        endcase
    end

    always_comb begin
        if (bad_flag)      stat_code = 8'hFF;
        else if (to_flag)  stat_code = 8'hEF;
        else if (err_flag) stat_code = 8'hEE;
        else if (ovf_flag) stat_code = 8'hEC;
        else               stat_code = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp] <= ram_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            opcode         <= '0;
            argc           <= '0;
            wr_left        <= '0;
            first_cyc      <= 1'b0;
            wait_cnt       <= '0;
            to_flag        <= 1'b0;
            err_flag       <= 1'b0;
            ovf_flag       <= 1'b0;
            bad_flag       <= 1'b0;
            stat_pending   <= 1'b0;
            stat_byte      <= '0;
            wr_byte_q      <= '0;
            X1             <= '0;
            Y1             <= '0;
            X2             <= '0;
            Y2             <= '0;
            op_x_width     <= '0;
            op_y_height    <= '0;
            fill_value     <= 1'b0;
            start_fill     <= 1'b0;
            start_blit     <= 1'b0;
            start_ram_read <= 1'b0;
        end else begin
            start_fill     <= 1'b0;
            start_blit     <= 1'b0;
            start_ram_read <= 1'b0;
            if (ram_byte_ready && fifo_full && !pop)
                ovf_flag <= 1'b1;
            if (error && (state == S_ISSUE || state == S_WAIT ||
                          state == S_WDATA || state == S_WWAIT))
                err_flag <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        opcode <= in_byte;
                        argc   <= '0;
                        if (in_byte >= OP_FILL && in_byte <= OP_WRITE) begin
                            state <= S_ARGS;
                        end else begin
                            bad_flag <= 1'b1;
                            state    <= S_STATUS;
                        end
                    end
                end
                S_ARGS: begin
                    if (in_valid) begin
                        argc <= argc + 4'd1;
                        case (argc)
                            4'd0: X1[7:0] <= in_byte;
                            4'd1: X1[8]   <= in_byte[0];
                            4'd2: Y1      <= in_byte;
                            4'd3: if (opcode == OP_BLIT) X2[7:0] <= in_byte;
                                  else op_x_width[7:0] <= in_byte;
                            4'd4: if (opcode == OP_BLIT) X2[8] <= in_byte[0];
                                  else op_x_width[8] <= in_byte[0];
                            4'd5: if (opcode == OP_BLIT) Y2 <= in_byte;
                                  else op_y_height <= in_byte;
                            4'd6: if (opcode == OP_BLIT) op_x_width[7:0] <= in_byte;
                                  else if (opcode == OP_FILL) fill_value <= in_byte[0];
                                  else wr_left[7:0] <= in_byte;
                            4'd7: if (opcode == OP_BLIT) op_x_width[8] <= in_byte[0];
                                  else wr_left[15:8] <= in_byte;
                            default: op_y_height <= in_byte;
                        endcase
                        if (argc == last_arg) begin
                            // WRITE has no op-level start; each data byte is its own card op.
                            state          <= S_ISSUE;
                            start_fill     <= (opcode == OP_FILL);
                            start_blit     <= (opcode == OP_BLIT);
                            start_ram_read <= (opcode == OP_READ);
                        end
                    end
                end
                S_ISSUE: begin
                    state     <= S_WAIT;
                    first_cyc <= 1'b1;
                    wait_cnt  <= '0;
                end
                S_WAIT, S_WWAIT: begin
                    first_cyc <= 1'b0;
                    if (!first_cyc && !busy) begin
                        if (state == S_WAIT) begin
                            if (opcode == OP_WRITE && wr_left != 16'd0) state <= S_WDATA;
                            else                                        state <= S_STATUS;
                        end else begin
                            wr_left <= wr_left - 16'd1;
                            state   <= (wr_left == 16'd1) ? S_STATUS : S_WDATA;
                        end
                    end else if (wait_cnt == TO_LAST) begin
                        to_flag <= 1'b1;
                        state   <= S_STATUS;
                    end else begin
                        wait_cnt <= wait_cnt + 20'd1;
                    end
                end
                S_WDATA: begin
                    if (in_valid) begin
                        wr_byte_q <= in_byte;
                        state     <= S_WWAIT;
                        first_cyc <= 1'b1;
                        wait_cnt  <= '0;
                    end
                end
                S_STATUS: begin
                    if (!stat_pending) begin
                        if (fifo_empty) begin
                            stat_pending <= 1'b1;
                            stat_byte    <= stat_code;
                        end
                    end else if (out_ready) begin
                        stat_pending <= 1'b0;
                        to_flag      <= 1'b0;
                        err_flag     <= 1'b0;
                        ovf_flag     <= 1'b0;
                        bad_flag     <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_cmd_host.sv
// tb/tb_gpu_cmd_host.sv - table-driven bench for gpu_cmd_host with a behavioural card model
module tb_gpu_cmd_host;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] X1, X2, op_x_width;
    logic [7:0] Y1, Y2, op_y_height;
    logic       fill_value;
    logic       start_fill, start_blit, start_ram_read, start_ram_write;
    logic [7:0] write_ram_byte;
    logic       busy;
    logic       error;
    logic       ram_byte_ready;
    logic [7:0] ram_byte;
    logic       host_busy;

    always #5 clk = ~clk;

    gpu_cmd_host #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .X1(X1), .Y1(Y1), .X2(X2), .Y2(Y2),
        .op_x_width(op_x_width), .op_y_height(op_y_height), .fill_value(fill_value),
        .start_fill(start_fill), .start_blit(start_blit),
        .start_ram_read(start_ram_read), .start_ram_write(start_ram_write),
        .write_ram_byte(write_ram_byte),
        .busy(busy), .error(error),
        .ram_byte_ready(ram_byte_ready), .ram_byte(ram_byte),
        .host_busy(host_busy)
    );

    // Card model: busy for busy_len cycles after any start, optional error pulse, read-back bytes.
    int         busy_len   = 0;
    bit         busy_stuck = 1'b0;
    bit         err_inject = 1'b0;
    int         read_n     = 0;
    logic [7:0] read_data [8];
    int         busy_rem   = 0;
    int         rd_left    = 0;
    int         rd_idx     = 0;
    int         n_fill = 0, n_blit = 0, n_read = 0, n_write = 0, n_viol = 0;
    logic [7:0] wlog [16];

    assign busy = busy_stuck || (busy_rem != 0);

    always @(posedge clk) begin
        if (reset) begin
            busy_rem       <= 0;
            rd_left        <= 0;
            rd_idx         <= 0;
            error          <= 1'b0;
            ram_byte_ready <= 1'b0;
            ram_byte       <= 8'h00;
        end else begin
            error          <= 1'b0;
            ram_byte_ready <= 1'b0;
            if (start_fill || start_blit || start_ram_read || start_ram_write) begin
                busy_rem <= busy_len;
                if (err_inject) error <= 1'b1;
            end else if (busy_rem > 0) begin
                busy_rem <= busy_rem - 1;
            end
            if (start_fill)     n_fill <= n_fill + 1;
            if (start_blit)     n_blit <= n_blit + 1;
            if (start_ram_read) n_read <= n_read + 1;
            if (start_ram_write) begin
                if (busy) n_viol <= n_viol + 1;
                wlog[n_write % 16] <= write_ram_byte;
                n_write <= n_write + 1;
            end
            if (start_ram_read) begin
                rd_left <= read_n;
                rd_idx  <= 0;
            end else if (rd_left > 0) begin
                ram_byte_ready <= 1'b1;
                ram_byte       <= read_data[rd_idx];
                rd_idx         <= rd_idx + 1;
                rd_left        <= rd_left - 1;
            end
        end
    end

    typedef struct {
        int          len;
        logic [95:0] pkt;
        int          busy;
        bit          err;
        logic [8:0]  x1;
        logic [7:0]  y1;
        logic [8:0]  x2;
        logic [7:0]  y2;
        logic [8:0]  w;
        logic [7:0]  h;
        bit          fv;
        logic [7:0]  st;
        int          nf, nb, nr;
    } vec_t;

    vec_t tbl [6];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_byte  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t == 200) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_packet(input int len, input logic [95:0] pkt);
        for (int i = 0; i < len; i++)
            send_byte(pkt[8*(len-1-i) +: 8]);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        bit ok;
        ok = 1'b0;
        b  = 8'h00;
        out_ready = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            if (out_valid) begin
                b  = out_byte;
                ok = 1'b1;
            end
            @(negedge clk);
        end
        if (!ok) check("recv_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int f0, b0, r0, w0, v0, k;

        tbl[0] = '{len:8,  pkt:96'h010A000514000801, busy:10, err:0,
                   x1:9'd10, y1:8'd5, x2:9'd0, y2:8'd0, w:9'd20, h:8'd8, fv:1,
                   st:8'h00, nf:1, nb:0, nr:0};
        tbl[1] = '{len:10, pkt:96'h023F010710FE20040130, busy:0, err:0,
                   x1:9'd319, y1:8'd7, x2:9'd16, y2:8'h20, w:9'd260, h:8'h30, fv:1,
                   st:8'h00, nf:0, nb:1, nr:0};
        tbl[2] = '{len:1,  pkt:96'h7E, busy:0, err:0,
                   x1:9'd319, y1:8'd7, x2:9'd16, y2:8'h20, w:9'd260, h:8'h30, fv:1,
                   st:8'hFF, nf:0, nb:0, nr:0};
        tbl[3] = '{len:8,  pkt:96'h010001FF0101FF00, busy:3, err:1,
                   x1:9'd256, y1:8'hFF, x2:9'd16, y2:8'h20, w:9'd257, h:8'hFF, fv:0,
                   st:8'hEE, nf:1, nb:0, nr:0};
        tbl[4] = '{len:9,  pkt:96'h040100020300040000, busy:2, err:0,
                   x1:9'd1, y1:8'd2, x2:9'd16, y2:8'h20, w:9'd3, h:8'd4, fv:0,
                   st:8'h00, nf:0, nb:0, nr:0};
        tbl[5] = '{len:7,  pkt:96'h03050006070008, busy:2, err:0,
                   x1:9'd5, y1:8'd6, x2:9'd16, y2:8'h20, w:9'd7, h:8'd8, fv:0,
                   st:8'h00, nf:0, nb:0, nr:1};

        reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_X1", X1, 0);
        check("rst_op_y_height", op_y_height, 0);
        check("rst_host_busy", host_busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_starts", {start_fill, start_blit, start_ram_read, start_ram_write}, 0);

        for (int i = 0; i < 6; i++) begin
            busy_len = tbl[i].busy; err_inject = tbl[i].err; read_n = 0;
            f0 = n_fill; b0 = n_blit; r0 = n_read; w0 = n_write;
            send_packet(tbl[i].len, tbl[i].pkt);
            recv_byte(b);
            check($sformatf("v%0d_status", i), b, tbl[i].st);
            check($sformatf("v%0d_X1", i), X1, tbl[i].x1);
            check($sformatf("v%0d_Y1", i), Y1, tbl[i].y1);
            check($sformatf("v%0d_X2", i), X2, tbl[i].x2);
            check($sformatf("v%0d_Y2", i), Y2, tbl[i].y2);
            check($sformatf("v%0d_W", i), op_x_width, tbl[i].w);
            check($sformatf("v%0d_H", i), op_y_height, tbl[i].h);
            check($sformatf("v%0d_fill_value", i), fill_value, tbl[i].fv);
            check($sformatf("v%0d_n_fill", i), n_fill - f0, tbl[i].nf);
            check($sformatf("v%0d_n_blit", i), n_blit - b0, tbl[i].nb);
            check($sformatf("v%0d_n_read", i), n_read - r0, tbl[i].nr);
            check($sformatf("v%0d_n_write", i), n_write - w0, 0);
        end
        err_inject = 1'b0;

        // READ with three back-to-back read-back bytes
        read_data[0] = 8'hAA; read_data[1] = 8'hBB; read_data[2] = 8'hCC;
        read_n = 3; busy_len = 5;
        send_packet(7, 96'h03010002030004);
        recv_byte(b); check("rd3_b0", b, 8'hAA);
        recv_byte(b); check("rd3_b1", b, 8'hBB);
        recv_byte(b); check("rd3_b2", b, 8'hCC);
        recv_byte(b); check("rd3_status", b, 8'h00);

        // READ of six bytes into a four-entry buffer with the sink stalled
        for (int i = 0; i < 6; i++) read_data[i] = 8'(8'h11 * (i + 1));
        read_n = 6; busy_len = 8;
        out_ready = 1'b0;
        send_packet(7, 96'h03010002030004);
        repeat (20) @(negedge clk);
        check("ovf_stalled_valid", out_valid, 1);
        check("ovf_host_busy", host_busy, 1);
        recv_byte(b); check("ovf_b0", b, 8'h11);
        recv_byte(b); check("ovf_b1", b, 8'h22);
        recv_byte(b); check("ovf_b2", b, 8'h33);
        recv_byte(b); check("ovf_b3", b, 8'h44);
        recv_byte(b); check("ovf_status", b, 8'hEC);
        read_n = 0;

        // WRITE N=2: each data byte waits for the previous card op to finish
        busy_len = 4;
        w0 = n_write; v0 = n_viol;
        send_packet(9, 96'h040100020300040200);
        send_byte(8'h55);
        send_byte(8'h66);
        recv_byte(b);
        check("wr_status", b, 8'h00);
        check("wr_pulses", n_write - w0, 2);
        check("wr_byte0", wlog[w0 % 16], 8'h55);
        check("wr_byte1", wlog[(w0 + 1) % 16], 8'h66);
        check("wr_busy_overlap", n_viol - v0, 0);

        // Busy stuck high: status appears TIMEOUT wait cycles plus ISSUE and STATUS later
        busy_stuck = 1'b1;
        send_packet(8, 96'h0102000300040501);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("to_latency", k, 18);
        recv_byte(b);
        check("to_status", b, 8'hEF);
        busy_stuck = 1'b0;
        check("to_idle", host_busy, 0);

        // Reset while waiting on the card
        busy_len = 20;
        send_packet(8, 96'h0133014455006601);
        repeat (3) @(negedge clk);
        check("rstw_in_wait", host_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstw_X1", X1, 0);
        check("rstw_Y1", Y1, 0);
        check("rstw_W", op_x_width, 0);
        check("rstw_H", op_y_height, 0);
        check("rstw_fill_value", fill_value, 0);
        check("rstw_host_busy", host_busy, 0);
        check("rstw_out_valid", out_valid, 0);
        check("rstw_in_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
